// File: rtl/telemetry_framer.sv
// Telemetry frame builder: snapshots channel words and streams SYNC, seq, count,
// per-channel index/data bytes and an XOR checksum to a byte-wide transmitter.
module telemetry_framer #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CH_BYTES = 2,
  parameter logic [7:0]  SYNC     = 8'hA5,
  parameter int unsigned PERIOD   = 500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         start,
  input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_mask,
  output logic [7:0]                   tx_data,
  output logic                         new_tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_block,
  output logic                         frame_active,
  output logic                         frame_done,
  output logic [7:0]                   seq,
  output logic                         overrun
);

  localparam int unsigned WB = CH_BYTES * 8;
  localparam int unsigned CW = $clog2(NUM_CH + 1);
  localparam int unsigned BW = (CH_BYTES > 1) ? $clog2(CH_BYTES) : 1;
  localparam int unsigned PW = $clog2(PERIOD);

  typedef enum logic [2:0] {IDLE, SNAP, SEND, WAIT, NEXT, DONE} state_t;
  typedef enum logic [2:0] {P_SYNC, P_SEQ, P_CNT, P_IDX, P_DATA, P_SCAN, P_CSUM} phase_t;

  state_t                   state, state_n;
  phase_t                   phase;
  logic [CW-1:0]            ch;
  logic [BW-1:0]            bidx;
  logic [7:0]               csum;
  logic                     pending;
  logic [PW-1:0]            per_cnt;
  logic [NUM_CH*WB-1:0]     data_q;
  logic [NUM_CH-1:0]        mask_q;

  logic                     ch_en;
  logic [WB-1:0]            ch_word;
  logic [7:0]               data_byte;
  logic [7:0]               mask_cnt;
  logic [7:0]               cur_byte;
  logic                     accept;
  logic                     last_byte;
  logic                     scan_end;
  logic                     per_wrap;
  logic                     req;
  logic                     take;

  // Channel/byte selection from the snapshot copies only
  always_comb begin
    ch_en     = 1'b0;
    ch_word   = '0;
    data_byte = '0;
    mask_cnt  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch == CW'(k)) begin
        ch_en   = mask_q[k];
        ch_word = data_q[k*WB +: WB];
      end
      mask_cnt = mask_cnt + 8'(mask_q[k]);
    end
    for (int unsigned b = 0; b < CH_BYTES; b++) begin
      if (bidx == BW'(b)) data_byte = ch_word[(CH_BYTES-1-b)*8 +: 8];
    end
  end

  always_comb begin
    case (phase)
      P_SYNC:  cur_byte = SYNC;
      P_SEQ:   cur_byte = seq;
      P_CNT:   cur_byte = mask_cnt;
      P_IDX:   cur_byte = 8'(ch);
      P_DATA:  cur_byte = data_byte;
      P_CSUM:  cur_byte = csum;
      default: cur_byte = 8'h00;
    endcase
  end

  assign accept    = (state == SEND) && !tx_busy && !tx_block;
  assign last_byte = (bidx == BW'(CH_BYTES - 1));
  assign scan_end  = (ch == CW'(NUM_CH));
  assign per_wrap  = (per_cnt == PW'(PERIOD - 1));
  assign req       = mode ? start : per_wrap;
  assign take      = (state == IDLE) && pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (pending) state_n = SNAP;
      SNAP: state_n = SEND;
      SEND: if (accept) state_n = WAIT;
      WAIT: if (!tx_busy) state_n = NEXT;
      NEXT: begin
        case (phase)
          P_CNT:   state_n = NEXT;
          P_DATA:  state_n = last_byte ? NEXT : SEND;
          P_SCAN:  state_n = (scan_end || ch_en) ? SEND : NEXT;
          P_CSUM:  state_n = DONE;
          default: state_n = SEND;
        endcase
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_data      = (state == SEND) ? cur_byte : 8'h00;
    new_tx_data  = accept;
    frame_active = (state == SNAP) || (state == SEND) || (state == WAIT) || (state == NEXT);
    frame_done   = (state == DONE);
  end

  // Byte pointer advances in NEXT; disabled channels cost one NEXT cycle each
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= P_SYNC;
      ch     <= '0;
      bidx   <= '0;
      csum   <= '0;
      seq    <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      case (state)
        SNAP: begin
          data_q <= ch_data;
          mask_q <= ch_mask;
          phase  <= P_SYNC;
          ch     <= '0;
          bidx   <= '0;
          csum   <= '0;
        end
        SEND: if (accept && phase != P_SYNC && phase != P_CSUM) csum <= csum ^ cur_byte;
        NEXT: begin
          case (phase)
            P_SYNC: phase <= P_SEQ;
            P_SEQ:  phase <= P_CNT;
            P_CNT: begin
              ch    <= '0;
              phase <= P_SCAN;
            end
            P_IDX: begin
              bidx  <= '0;
              phase <= P_DATA;
            end
            P_DATA: begin
              if (last_byte) begin
                ch    <= ch + 1'b1;
                phase <= P_SCAN;
              end else begin
                bidx <= bidx + 1'b1;
              end
            end
            P_SCAN: begin
              if (scan_end)   phase <= P_CSUM;
              else if (ch_en) phase <= P_IDX;
              else            ch    <= ch + 1'b1;
            end
            default: phase <= phase;
          endcase
        end
        DONE:    seq <= seq + 8'd1;
        default: ;
      endcase
    end
  end

  // A request landing in the same cycle the pending one is consumed is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
      per_cnt <= '0;
    end else begin
      per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
      if (req) begin
        if (pending && !take) overrun <= 1'b1;
        else                  pending <= 1'b1;
      end else if (take) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
